fetch_unit: RTL and testbench
=============================

# fetch_unit

- Four-wide instruction fetch stage directly upstream of the instruction buffer.
- Generates sequential 16-byte fetch requests to a synchronous instruction memory.
- Stages the returned words in a small circular fetch queue and presents up to four instructions per cycle on the buffer's `Iin1..Iin4` inputs.
- Pops exactly as many as the buffer reports accepting via `in_count`, and restarts from a new PC on redirect (branch/flush).

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, fetch address after reset (bits [1:0] must be 0).
- `QDEPTH`, 8, fetch queue entries; power of two, ≥8.

Ports:
- `clk`  in  1  sole clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `redirect`  in  1  flush queue, kill in-flight fetch, restart at `redirect_pc`.
- `redirect_pc`  in  32  new fetch address; bits [1:0] ignored (treated as 0).
- `in_count`  in  3  instructions the buffer accepts this cycle, 0..4.
- `imem_req`  out  1  fetch request this cycle.
- `imem_addr`  out  32  request address (word-aligned).
- `imem_rdata1..imem_rdata4`  in  32 each  words at `addr`, +4, +8, +12; valid the cycle after `imem_req`.
- `Iin1..Iin4`  out  32 each  queue head entries 0..3.
- `Iin1Valid..Iin4Valid`  out  1 each  entry k valid iff k ≤ occupancy.
- `fetch_pc`  out  32  next request address (the PC register).

## Operation
- State:
  - `pc` (32 bits)
  - queue array (`QDEPTH` × 32)
  - `head` and `tail` pointers (log2 `QDEPTH` bits, wrap modulo `QDEPTH`)
  - `count` (0..`QDEPTH`)
  - `inflight` flag
- Outputs are driven from registers only. `Iin_k = queue[head+k-1]`. An invalid slot drives 32'h0.
- Pop: `pop = min(in_count, count)`. `head += pop` and `count -= pop`.
  - `in_count` larger than occupancy is legal and clamps.
  - `in_count` values 5..7 are treated as 4.
- Push: when `inflight` is set and `redirect` is low, the four `imem_rdata` words are written at `tail..tail+3` (wrapping), then `tail += 4` and `count += 4`.
- Pop and push may occur in the same cycle: `count_next = count - pop + push*4`.
- Request rule: `imem_req = !redirect && (count - pop + 4*inflight) ≤ QDEPTH-4`.
  - This guarantees the queue never overflows.
  - On a request: `imem_addr = pc`, `pc += 16`, and `inflight` is set next cycle (otherwise cleared).
- Redirect has priority over everything else:
  - `count`, `head`, `tail` and `inflight` are set to 0.
  - `pc` is loaded with `{redirect_pc[31:2], 2'b00}`.
  - No pop or push takes effect.
  - Any response arriving next cycle for a pre-redirect request is discarded, because `inflight` is cleared.
- `pc` wraps modulo 2^32 without any special handling.

## Timing
- Reset values (asynchronous assertion, released synchronously by the clock domain):
  - `pc = RESET_PC`, `count = 0`, `head = 0`, `tail = 0`, `inflight = 0`.
  - All `IinkValid = 0`, all `Iin = 0`, `imem_req = 0` while in reset.
  - `fetch_pc = RESET_PC`.
- First cycle after reset release: `imem_req = 1` with `imem_addr = RESET_PC`.
- Latency: request in cycle t → data captured at the end of t+1 → visible on `Iin1..4` with valid in t+2.
- Throughput: a sustained 4 instructions/cycle when `in_count = 4` every cycle. In steady state, `count = 4` and `inflight = 1`, giving 4-4+4 = 4 ≤ 4.
- Stall: with `in_count = 0`, requests stop once `count + 4*inflight > QDEPTH-4`, i.e. the queue holds at 8 entries for `QDEPTH = 8`.
- Redirect in cycle t:
  - The request from `redirect_pc` issues in t+1.
  - Its instructions are visible in t+3.
  - `Iin*Valid` are 0 in cycles t+1 and t+2.
- Reset mid-operation: all state returns to reset values immediately. The in-flight response is ignored.

## Configuration
- `FETCH_PERF_EN` defined: adds an output port `fetch_stall_cycles` (32 bits, reset 0).
  - It increments (saturating at 32'hFFFF_FFFF) every cycle in which `count == 0`, `inflight == 0` and `redirect == 0`, i.e. the buffer is starved.
- `FETCH_PERF_EN` undefined: the port and counter are absent. Functional behaviour is otherwise identical.

## Test plan
- **Reset and first fetch:**
  - Stimulus: `RESET_PC = 0x100`, release reset, `in_count = 4` each cycle.
  - Required: `imem_req` with addr 0x100, 0x110, 0x120 on consecutive cycles; `Iin1..4` = mem[0x100..0x10C] all valid in cycle 2.
- **Backpressure:**
  - Stimulus: `in_count = 0` after reset.
  - Required: exactly two requests (0x100, 0x110); valid stays 4'b1111; `fetch_pc` holds 0x120; no overflow or loss.
- **Partial pops with wrap:**
  - Stimulus: `in_count` sequence 1,3,2,4,1 repeated for 40 cycles.
  - Required: the concatenated accepted stream equals consecutive words from 0x100 with no gaps or duplicates across `head`/`tail` wrap.
- **Redirect with in-flight fetch:**
  - Stimulus: `redirect = 1`, `redirect_pc = 0x2003` in the cycle after a request to 0x140.
  - Required: 0x140 data never appears; next request is 0x2000; valids are 0 for two cycles; then mem[0x2000..0x200C] is presented.
- **Simultaneous push and pop:**
  - Stimulus: `count = 4`, `inflight = 1`, `in_count = 2`.
  - Required: next `count = 6`; `Iin1` = old entry 2; no request that cycle (6+0 > 4).
- **Mid-operation reset:**
  - Stimulus: assert `reset` asynchronously between clock edges while the queue holds 6 entries.
  - Required: valids drop immediately; after release, fetch restarts at `RESET_PC`; with `FETCH_PERF_EN` the stall counter reads 0.

Source files
------------

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: instruction-memory request/response plus the four-wide instruction buffer port.
// master = fetch unit, slave = memory/buffer side.
interface fetch_unit_if;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [2:0]  in_count;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata1;
  logic [31:0] imem_rdata2;
  logic [31:0] imem_rdata3;
  logic [31:0] imem_rdata4;
  logic [31:0] Iin1;
  logic [31:0] Iin2;
  logic [31:0] Iin3;
  logic [31:0] Iin4;
  logic        Iin1Valid;
  logic        Iin2Valid;
  logic        Iin3Valid;
  logic        Iin4Valid;
  logic [31:0] fetch_pc;

  modport master (
    input  redirect, redirect_pc, in_count,
    input  imem_rdata1, imem_rdata2, imem_rdata3, imem_rdata4,
    output imem_req, imem_addr,
    output Iin1, Iin2, Iin3, Iin4,
    output Iin1Valid, Iin2Valid, Iin3Valid, Iin4Valid,
    output fetch_pc
  );

  modport slave (
    output redirect, redirect_pc, in_count,
    output imem_rdata1, imem_rdata2, imem_rdata3, imem_rdata4,
    input  imem_req, imem_addr,
    input  Iin1, Iin2, Iin3, Iin4,
    input  Iin1Valid, Iin2Valid, Iin3Valid, Iin4Valid,
    input  fetch_pc
  );
endinterface

// File: rtl/fetch_unit.sv
// 4-wide sequential fetch into a circular queue; request in t -> Iin valid in t+2; requests stall while
// queue+inflight would exceed QDEPTH-4, pops clamp to occupancy. FETCH_PERF_EN adds fetch_stall_cycles.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned QDEPTH   = 8
) (
  input  logic        clk,
  input  logic        reset,
`ifdef FETCH_PERF_EN
  output logic [31:0] fetch_stall_cycles,
`endif
  fetch_unit_if.master bus
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;

  typedef logic [PW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;

  logic [31:0] pc;
  logic [31:0] queue [QDEPTH];
  ptr_t        head;
  ptr_t        tail;
  cnt_t        count;
  logic        inflight;

  cnt_t        ic_eff;
  cnt_t        pop;
  cnt_t        level;
  logic        push;
  logic        req;
  logic [31:0] wdata [4];
  logic [31:0] head_word [4];
  logic [3:0]  vld;
  logic        unused_pc_bits;

  assign wdata[0] = bus.imem_rdata1;
  assign wdata[1] = bus.imem_rdata2;
  assign wdata[2] = bus.imem_rdata3;
  assign wdata[3] = bus.imem_rdata4;
  assign unused_pc_bits = ^bus.redirect_pc[1:0];

  // level is both the occupancy after this cycle and the request-gating term
  always_comb begin
    ic_eff = (bus.in_count > 3'd4) ? cnt_t'(4) : cnt_t'(bus.in_count);
    pop    = (ic_eff < count) ? ic_eff : count;
    level  = count - pop + (inflight ? cnt_t'(4) : cnt_t'(0));
    push   = inflight && !bus.redirect;
    req    = reset && !bus.redirect && (level <= cnt_t'(QDEPTH - 4));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc       <= RESET_PC;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      inflight <= 1'b0;
    end else if (bus.redirect) begin
      pc       <= {bus.redirect_pc[31:2], 2'b00};
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      inflight <= 1'b0;
    end else begin
      head     <= head + ptr_t'(pop);
      count    <= level;
      inflight <= req;
      if (push) tail <= tail + ptr_t'(4);
      if (req)  pc   <= pc + 32'd16;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      for (int k = 0; k < 4; k++) begin
        queue[tail + ptr_t'(k)] <= wdata[k];
      end
    end
  end

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      vld[k]       = cnt_t'(k) < count;
      head_word[k] = vld[k] ? queue[head + ptr_t'(k)] : 32'h0;
    end
  end

  assign bus.imem_req  = req;
  assign bus.imem_addr = pc;
  assign bus.fetch_pc  = pc;
  assign bus.Iin1      = head_word[0];
  assign bus.Iin2      = head_word[1];
  assign bus.Iin3      = head_word[2];
  assign bus.Iin4      = head_word[3];
  assign bus.Iin1Valid = vld[0];
  assign bus.Iin2Valid = vld[1];
  assign bus.Iin3Valid = vld[2];
  assign bus.Iin4Valid = vld[3];

`ifdef FETCH_PERF_EN
  // Counts starved cycles: nothing queued and nothing on its way
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_stall_cycles <= '0;
    end else if (count == '0 && !inflight && !bus.redirect && fetch_stall_cycles != 32'hFFFF_FFFF) begin
      fetch_stall_cycles <= fetch_stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboarded bench for fetch_unit: expected request addresses and instruction words are queued by the
// stimulus, a negedge monitor pops and compares them as the DUT issues requests and the buffer accepts words.
module tb_fetch_unit;
  localparam logic [31:0] RPC = 32'h0000_0100;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fetch_unit_if bus();
`ifdef FETCH_PERF_EN
  logic [31:0] stall_cnt;
`endif

  fetch_unit #(.RESET_PC(RPC), .QDEPTH(8)) dut (
    .clk(clk),
    .reset(reset),
`ifdef FETCH_PERF_EN
    .fetch_stall_cycles(stall_cnt),
`endif
    .bus(bus)
  );

  int checks = 0;
  int passes = 0;
  int n_req  = 0;
  int n_acc  = 0;
  logic [31:0] exp_req[$];
  logic [31:0] exp_stream[$];

  function automatic logic [31:0] memf(input logic [31:0] a);
    return a ^ 32'h5A00_0000;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Memory model: answers the address seen mid-cycle at the start of the next cycle
  logic [31:0] pend_addr = 32'h0;
  always @(negedge clk) if (bus.imem_req === 1'b1) pend_addr = bus.imem_addr;
  always @(posedge clk) begin
    #1;
    bus.imem_rdata1 = memf(pend_addr);
    bus.imem_rdata2 = memf(pend_addr + 32'd4);
    bus.imem_rdata3 = memf(pend_addr + 32'd8);
    bus.imem_rdata4 = memf(pend_addr + 32'd12);
  end

  // Monitor
  logic [3:0]  mv;
  logic [31:0] mw [4];
  int          mnv, mic, mtake;
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      if (bus.imem_req === 1'b1) begin
        n_req++;
        if (exp_req.size() == 0) begin
          checks++;
          $display("FAIL unexpected_req: got %h expected none", bus.imem_addr);
        end else begin
          check("req_addr", bus.imem_addr, exp_req.pop_front());
        end
      end
      if (bus.redirect !== 1'b1) begin
        mv    = {bus.Iin4Valid, bus.Iin3Valid, bus.Iin2Valid, bus.Iin1Valid};
        mw[0] = bus.Iin1; mw[1] = bus.Iin2; mw[2] = bus.Iin3; mw[3] = bus.Iin4;
        mnv   = 0;
        for (int k = 0; k < 4; k++) if (mv[k]) mnv++;
        mic   = (bus.in_count > 3'd4) ? 4 : int'(bus.in_count);
        mtake = (mic < mnv) ? mic : mnv;
        for (int k = 0; k < mtake; k++) begin
          n_acc++;
          if (exp_stream.size() == 0) begin
            checks++;
            $display("FAIL unexpected_word: got %h expected none", mw[k]);
          end else begin
            check("stream_word", mw[k], exp_stream.pop_front());
          end
        end
      end
    end
  end

  task automatic refill(input logic [31:0] base);
    exp_req.delete();
    exp_stream.delete();
    for (int i = 0; i < 128; i++) exp_req.push_back(base + 32'(16 * i));
    for (int i = 0; i < 512; i++) exp_stream.push_back(memf(base + 32'(4 * i)));
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic leave_reset();
    refill(RPC);
    n_req = 0;
    n_acc = 0;
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic enter_reset();
    reset = 1'b0;
    bus.redirect = 1'b0;
    @(negedge clk);
  endtask

  function automatic logic [31:0] valids();
    return {28'h0, bus.Iin4Valid, bus.Iin3Valid, bus.Iin2Valid, bus.Iin1Valid};
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset           = 1'b0;
    bus.in_count    = 3'd0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 32'h0;
    bus.imem_rdata1 = 32'h0;
    bus.imem_rdata2 = 32'h0;
    bus.imem_rdata3 = 32'h0;
    bus.imem_rdata4 = 32'h0;
    repeat (2) @(negedge clk);
    check("rst_valids", valids(), 32'h0);
    check("rst_iin1", bus.Iin1, 32'h0);
    check("rst_req", {31'h0, bus.imem_req}, 32'h0);
    check("rst_fetch_pc", bus.fetch_pc, RPC);

    // Reset and first fetch, full-rate consumption
    bus.in_count = 3'd4;
    leave_reset();
    repeat (10) next_cycle();
    enter_reset();
    check("a_nreq", n_req, 10);
    check("a_nacc", n_acc, 32);

    // Backpressure, then drain
    bus.in_count = 3'd0;
    leave_reset();
    repeat (7) next_cycle();
    @(negedge clk);
    check("b_valids", valids(), 32'hF);
    check("b_iin1", bus.Iin1, memf(32'h100));
    check("b_iin4", bus.Iin4, memf(32'h10C));
    check("b_fetch_pc", bus.fetch_pc, 32'h120);
    next_cycle();
    bus.in_count = 3'd4;
    repeat (6) next_cycle();
    enter_reset();
    check("b_nreq", n_req, 8);
    check("b_nacc", n_acc, 24);

    // Partial pops 1,3,2,4,1 across queue wrap, then full-rate drain
    leave_reset();
    for (int i = 0; i < 40; i++) begin
      case (i % 5)
        0: bus.in_count = 3'd1;
        1: bus.in_count = 3'd3;
        2: bus.in_count = 3'd2;
        3: bus.in_count = 3'd4;
        default: bus.in_count = 3'd1;
      endcase
      next_cycle();
    end
    bus.in_count = 3'd4;
    repeat (10) next_cycle();
    enter_reset();
    check("c_outstanding", 32'(4 * n_req - n_acc), 32'd8);
    check("c_enough_accepted", {31'h0, n_acc >= 64}, 32'h1);

    // Redirect while the 0x140 fetch is in flight; in_count 7 clamps to 4
    bus.in_count = 3'd7;
    leave_reset();
    repeat (5) next_cycle();
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h0000_2003;
    refill(32'h0000_2000);
    next_cycle();
    bus.redirect = 1'b0;
    @(negedge clk);
    check("d_valids_t1", valids(), 32'h0);
    next_cycle();
    @(negedge clk);
    check("d_valids_t2", valids(), 32'h0);
    next_cycle();
    @(negedge clk);
    check("d_valids_t3", valids(), 32'hF);
    check("d_iin1_t3", bus.Iin1, memf(32'h2000));
    repeat (4) next_cycle();
    enter_reset();
    check("d_nreq", n_req, 11);
    check("d_nacc", n_acc, 28);

    // Simultaneous push and pop, then reset mid-cycle with 6 entries queued
    bus.in_count = 3'd4;
    leave_reset();
    repeat (3) next_cycle();
    bus.in_count = 3'd2;
    @(negedge clk);
    check("e_no_req", {31'h0, bus.imem_req}, 32'h0);
    next_cycle();
    bus.in_count = 3'd0;
    @(negedge clk);
    check("e_valids", valids(), 32'hF);
    check("e_iin1_old_entry2", bus.Iin1, memf(32'h118));
    next_cycle();
    bus.in_count = 3'd4;
    next_cycle();
    bus.in_count = 3'd0;
    @(negedge clk);
    check("e_valids_two", valids(), 32'h3);
    check("e_iin1_wrap", bus.Iin1, memf(32'h128));
    check("e_iin3_invalid", bus.Iin3, 32'h0);
    next_cycle();
    #2;
    reset = 1'b0;
    #1;
    check("f_valids_drop", valids(), 32'h0);
    check("f_req_drop", {31'h0, bus.imem_req}, 32'h0);
    check("f_fetch_pc", bus.fetch_pc, RPC);
`ifdef FETCH_PERF_EN
    check("f_stall_cnt", stall_cnt, 32'h0);
`endif
    @(negedge clk);
    check("e_nreq", n_req, 4);
    check("e_nacc", n_acc, 10);

    bus.in_count = 3'd4;
    leave_reset();
    repeat (4) next_cycle();
    enter_reset();
    check("f_nreq", n_req, 4);
    check("f_nacc", n_acc, 8);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
